// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side consumer blocks:
// packer state encoding and the lane-count width helper.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_OUT  = 2'd2
    } pk_state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle-cycle counter with synchronous clear and enable; o_expire is high
// once LIMIT-1 enabled cycles have elapsed since the last clear.
module idle_timer #(
    parameter  int LIMIT = 16,
    localparam int TW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [TW-1:0] r_cnt;

    assign o_expire = (r_cnt == TW'(LIMIT - 1));

    // Saturates at the limit so a flush that is held off cannot wrap the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops narrow FIFO entries and packs PACK_NUM of them (lane 0 first) into a
// wide valid/ready word; a partial word is flushed as "last" after TIMEOUT idle clocks.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter  int FIFO_DWTH = 4,
    parameter  int PACK_NUM  = 4,
    parameter  int TIMEOUT   = 16,
    localparam int CW        = cnt_width(PACK_NUM)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FIFO_DWTH-1:0]          fifo_dout,
    input  logic                          fifo_valid,
    input  logic                          fifo_empty,
    output logic                          fifo_rden,
    output logic [FIFO_DWTH*PACK_NUM-1:0] pk_data,
    output logic [CW-1:0]                 pk_cnt,
    output logic                          pk_last,
    output logic                          pk_valid,
    input  logic                          pk_ready,
    output logic                          err
);

    pk_state_e                     r_state;
    pk_state_e                     w_state_nxt;
    logic                          r_rden;
    logic                          r_inflight;
    logic                          r_last;
    logic                          r_err;
    logic [CW-1:0]                 r_acc_cnt;
    logic [FIFO_DWTH*PACK_NUM-1:0] r_data;
    logic [CW:0]                   w_pending;
    logic                          w_acc;
    logic                          w_stray;
    logic                          w_full;
    logic                          w_expire;
    logic                          w_tmo;
    logic                          w_hs;
    logic                          w_rden_nxt;
    logic                          w_tmr_clr;
    logic                          w_tmr_en;

    assign w_acc   = fifo_valid && r_inflight;
    assign w_stray = fifo_valid && !r_inflight;
    assign w_full  = w_acc && (r_acc_cnt == CW'(PACK_NUM - 1));
    assign w_hs    = (r_state == ST_OUT) && pk_ready;
    // A flush must not race a read whose data is still on its way.
    assign w_tmo   = (r_state == ST_FILL) && w_expire && !r_inflight && !r_rden;

    // Entries already captured, arriving this cycle, and requested last cycle.
    assign w_pending  = {1'b0, r_acc_cnt} + {{CW{1'b0}}, r_inflight} + {{CW{1'b0}}, r_rden};
    assign w_rden_nxt = !fifo_empty &&
                        ((r_state == ST_OUT) ? pk_ready : (w_pending < (CW+1)'(PACK_NUM)));

    assign w_tmr_clr = w_acc || (r_state != ST_FILL);
    assign w_tmr_en  = (r_state == ST_FILL);

    idle_timer #(
        .LIMIT (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_acc)                 w_state_nxt = w_full ? ST_OUT : ST_FILL;
            ST_FILL: if (w_full || w_tmo)       w_state_nxt = ST_OUT;
            ST_OUT:  if (pk_ready)              w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rden     <= 1'b0;
            r_inflight <= 1'b0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
            r_acc_cnt  <= '0;
            r_data     <= '0;
        end else begin
            r_rden     <= w_rden_nxt;
            r_inflight <= r_rden && !fifo_empty;
            if (w_stray) begin
                r_err <= 1'b1;
            end
            if (w_hs) begin
                r_acc_cnt <= '0;
                r_data    <= '0;
                r_last    <= 1'b0;
            end else if (w_acc) begin
                for (int i = 0; i < PACK_NUM; i++) begin
                    if (r_acc_cnt == CW'(i)) begin
                        r_data[i*FIFO_DWTH +: FIFO_DWTH] <= fifo_dout;
                    end
                end
                r_acc_cnt <= r_acc_cnt + 1'b1;
            end else if (w_tmo) begin
                r_last <= 1'b1;
            end
        end
    end

    assign fifo_rden = r_rden;
    assign pk_data   = r_data;
    assign pk_cnt    = r_acc_cnt;
    assign pk_last   = r_last;
    assign pk_valid  = (r_state == ST_OUT);
    assign err       = r_err;

endmodule
